// File: rtl/cache_control_nway.sv
// cache_control_nway: FSM controller for an N-way set-associative,
// write-back, write-allocate cache with tree pseudo-LRU replacement.
// Hits respond from CHECK; misses pick a victim (invalid ways first, then
// PLRU), optionally write it back, refill it, then re-enter CHECK to hit.
module cache_control_nway #(
    parameter  int unsigned NUM_WAYS = 4,
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [NUM_WAYS-1:0]     hit_vec,
    input  logic [NUM_WAYS-1:0]     valid_in,
    input  logic [NUM_WAYS-1:0]     dirty_in,
    input  logic [NUM_WAYS-2:0]     plru_in,
    input  logic                    pmem_resp,
    output logic [NUM_WAYS-1:0]     ld_valid,
    output logic [NUM_WAYS-1:0]     ld_dirty,
    output logic [NUM_WAYS-1:0]     ld_tag,
    output logic                    valid_out,
    output logic                    dirty_out,
    output logic [2*NUM_WAYS-1:0]   w_en_mux_sel,
    output logic [NUM_WAYS-1:0]     data_in_mux_sel,
    output logic                    ld_plru,
    output logic [NUM_WAYS-2:0]     plru_out,
    output logic [WAY_W-1:0]        victim_way,
    output logic                    pmem_addr_mux_sel,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic                    mem_resp
);

    localparam int unsigned WEN_W = 2 * NUM_WAYS;

    localparam logic [1:0] WEN_FULL_LINE = 2'b01;
    localparam logic [1:0] WEN_CPU_BYTES = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WAY_W-1:0] victim_q;
    logic [WAY_W-1:0] victim_d;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] miss_victim;
    logic             is_write;

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [WAY_W-1:0] lowest_set(input logic [NUM_WAYS-1:0] vec);
        logic [NUM_WAYS-1:0] rem;
        logic [WAY_W-1:0]    cnt;
        logic [WAY_W-1:0]    idx;
        logic                found;
        rem   = vec;
        cnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (!found && rem[0]) begin
                idx   = cnt;
                found = 1'b1;
            end
            rem = rem >> 1;
            cnt = cnt + 1'b1;
        end
        return idx;
    endfunction

    function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [WAY_W-1:0] way);
        return NUM_WAYS'(1) << way;
    endfunction

    function automatic logic [WEN_W-1:0] wen_field(input logic [WAY_W-1:0] way,
                                                   input logic [1:0]       code);
        return WEN_W'(code) << {way, 1'b0};
    endfunction

    // Walk the PLRU tree from the root: bit 0 -> left child, bit 1 -> right.
    // Tree nodes are selected with a shifted one-hot mask so the node index
    // never has to match the tree vector's index width.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
        logic [WAY_W:0] node;
        logic           dir;
        node = '0;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            dir  = |(bits & ((NUM_WAYS-1)'(1) << node));
            node = {node[WAY_W-1:0], 1'b1} + {{WAY_W{1'b0}}, dir};
        end
        // Leaves occupy nodes N-1..2N-2; subtracting N-1 is +1 modulo N.
        return node[WAY_W-1:0] + 1'b1;
    endfunction

    // Point every node on the path to 'way' away from it; other nodes keep
    // their value. Path bits are taken MSB first from the way index.
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                       input logic [WAY_W-1:0]    way);
        logic [NUM_WAYS-2:0] tree;
        logic [NUM_WAYS-2:0] mask;
        logic [WAY_W:0]      node;
        logic [WAY_W-1:0]    path;
        logic                dir;
        tree = bits;
        node = '0;
        path = way;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            dir  = path[WAY_W-1];
            mask = (NUM_WAYS-1)'(1) << node;
            tree = dir ? (tree & ~mask) : (tree | mask);
            node = {node[WAY_W-1:0], 1'b1} + {{WAY_W{1'b0}}, dir};
            path = path << 1;
        end
        return tree;
    endfunction

    // State and latched victim; reset drops the machine straight to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            victim_q <= '0;
        end else begin
            state    <= next_state;
            victim_q <= victim_d;
        end
    end

    assign victim_way = victim_q;

    // Hit decode and victim choice for the addressed set.
    always_comb begin
        hit         = |hit_vec;
        hit_way     = lowest_set(hit_vec);
        miss_victim = (&valid_in) ? plru_victim(plru_in) : lowest_set(~valid_in);
        is_write    = mem_write;
    end

    // Next-state and all combinational outputs; everything idles at 0.
    always_comb begin
        next_state        = state;
        victim_d          = victim_q;
        ld_valid          = '0;
        ld_dirty          = '0;
        ld_tag            = '0;
        valid_out         = 1'b0;
        dirty_out         = 1'b0;
        w_en_mux_sel      = '0;
        data_in_mux_sel   = '0;
        ld_plru           = 1'b0;
        plru_out          = '0;
        pmem_addr_mux_sel = 1'b0;
        pmem_read         = 1'b0;
        pmem_write        = 1'b0;
        mem_resp          = 1'b0;

        unique case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    next_state = CHECK;
                end
            end

            CHECK: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    ld_plru  = 1'b1;
                    plru_out = plru_touch(plru_in, hit_way);
                    if (is_write) begin
                        ld_dirty     = way_onehot(hit_way);
                        dirty_out    = 1'b1;
                        w_en_mux_sel = wen_field(hit_way, WEN_CPU_BYTES);
                    end
                    next_state = IDLE;
                end else begin
                    victim_d = miss_victim;
                    if (valid_in[miss_victim] && dirty_in[miss_victim]) begin
                        next_state = WRITE_BACK;
                    end else begin
                        next_state = ALLOCATE;
                    end
                end
            end

            WRITE_BACK: begin
                pmem_write        = 1'b1;
                pmem_addr_mux_sel = 1'b1;
                if (pmem_resp) begin
                    next_state = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    ld_valid        = way_onehot(victim_q);
                    ld_tag          = way_onehot(victim_q);
                    ld_dirty        = way_onehot(victim_q);
                    valid_out       = 1'b1;
                    dirty_out       = 1'b0;
                    w_en_mux_sel    = wen_field(victim_q, WEN_FULL_LINE);
                    data_in_mux_sel = way_onehot(victim_q);
                    next_state      = CHECK;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_control_nway.sv
// tb_cache_control_nway: randomized check of the N=4 controller against a
// set-level reference model, plus a directed N=2 dirty-victim sequence.
module tb_cache_control_nway;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // N=4 instance signals
    logic           mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
    logic [N-1:0]   hit_vec, valid_in, dirty_in;
    logic [N-2:0]   plru_in;
    logic [N-1:0]   ld_valid, ld_dirty, ld_tag, data_in_mux_sel;
    logic           valid_out, dirty_out, ld_plru, pmem_addr_mux_sel;
    logic           pmem_read, pmem_write, mem_resp;
    logic [2*N-1:0] w_en_mux_sel;
    logic [N-2:0]   plru_out;
    logic [W-1:0]   victim_way;

    // N=2 instance signals
    logic       mem_read2 = 1'b0, mem_write2 = 1'b0, pmem_resp2 = 1'b0;
    logic [1:0] hit2 = '0, valid2 = '0, dirty2 = '0;
    logic [0:0] plru2 = '0;
    logic [1:0] ld_valid2, ld_dirty2, ld_tag2, dsel2;
    logic       valid_out2, dirty_out2, ld_plru2, asel2, pmem_read2, pmem_write2, mem_resp2;
    logic [3:0] w_en2;
    logic [0:0] plru_out2;
    logic [0:0] victim2;

    // Reference model of the addressed set (datapath state)
    int         m_tag   [N];
    bit         m_valid [N];
    bit         m_dirty [N];
    bit [N-2:0] m_plru;
    int         req_tag = -1;

    int n_checks = 0;
    int n_fail   = 0;

    cache_control_nway #(.NUM_WAYS(N)) u_dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .hit_vec(hit_vec), .valid_in(valid_in), .dirty_in(dirty_in), .plru_in(plru_in),
        .pmem_resp(pmem_resp),
        .ld_valid(ld_valid), .ld_dirty(ld_dirty), .ld_tag(ld_tag),
        .valid_out(valid_out), .dirty_out(dirty_out),
        .w_en_mux_sel(w_en_mux_sel), .data_in_mux_sel(data_in_mux_sel),
        .ld_plru(ld_plru), .plru_out(plru_out), .victim_way(victim_way),
        .pmem_addr_mux_sel(pmem_addr_mux_sel), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .mem_resp(mem_resp)
    );

    cache_control_nway #(.NUM_WAYS(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .mem_read(mem_read2), .mem_write(mem_write2),
        .hit_vec(hit2), .valid_in(valid2), .dirty_in(dirty2), .plru_in(plru2),
        .pmem_resp(pmem_resp2),
        .ld_valid(ld_valid2), .ld_dirty(ld_dirty2), .ld_tag(ld_tag2),
        .valid_out(valid_out2), .dirty_out(dirty_out2),
        .w_en_mux_sel(w_en2), .data_in_mux_sel(dsel2),
        .ld_plru(ld_plru2), .plru_out(plru_out2), .victim_way(victim2),
        .pmem_addr_mux_sel(asel2), .pmem_read(pmem_read2),
        .pmem_write(pmem_write2), .mem_resp(mem_resp2)
    );

    // Datapath emulation: set arrays feed the controller
    always_comb begin
        for (int i = 0; i < N; i++) begin
            hit_vec[i]  = m_valid[i] && (m_tag[i] == req_tag);
            valid_in[i] = m_valid[i];
            dirty_in[i] = m_dirty[i];
        end
        plru_in = m_plru;
    end

    // More than one matching way is an illegal datapath state
    always @(negedge clk) begin
        assert ($onehot0(hit_vec)) else $error("multiple hits %b", hit_vec);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input logic resp, input logic ldp, input logic [N-2:0] pl,
                                         input logic [N-1:0] ldv, input logic [N-1:0] ldd,
                                         input logic [N-1:0] ldt, input logic vo, input logic dout,
                                         input logic [2*N-1:0] wen, input logic [N-1:0] dsel,
                                         input logic asel, input logic pr, input logic pw);
        return 64'({resp, ldp, pl, ldv, ldd, ldt, vo, dout, wen, dsel, asel, pr, pw});
    endfunction

    // Compare all N=4 outputs (except victim_way) with an expected set;
    // plru_out and valid/dirty_out only matter when they are being loaded.
    task automatic exp_cycle(input string tag, input logic resp, input logic ldp,
                             input logic [N-2:0] pl, input logic [N-1:0] ldv,
                             input logic [N-1:0] ldd, input logic [N-1:0] ldt,
                             input logic vo, input logic dout, input logic [2*N-1:0] wen,
                             input logic [N-1:0] dsel, input logic asel, input logic pr,
                             input logic pw);
        logic ldany;
        logic [N-2:0] pl_obs;
        ldany  = |{ldv, ldd, ldt};
        pl_obs = ldp ? plru_out : '0;
        check(tag,
              pack(mem_resp, ld_plru, pl_obs, ld_valid, ld_dirty, ld_tag,
                   ldany ? valid_out : 1'b0, ldany ? dirty_out : 1'b0,
                   w_en_mux_sel, data_in_mux_sel, pmem_addr_mux_sel, pmem_read, pmem_write),
              pack(resp, ldp, pl, ldv, ldd, ldt, vo, dout, wen, dsel, asel, pr, pw));
    endtask

    task automatic exp_zero(input string tag);
        exp_cycle(tag, 0, 0, '0, '0, '0, '0, 0, 0, '0, '0, 0, 0, 0);
    endtask

    // Victim by rule: first invalid way, else walk the tree over way ranges
    function automatic int ref_victim();
        int lo = 0;
        int n = N;
        int node = 0;
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        while (n > 1) begin
            n = n / 2;
            if (m_plru[node]) begin lo += n; node = 2 * node + 2; end
            else node = 2 * node + 1;
        end
        return lo;
    endfunction

    function automatic bit [N-2:0] ref_touch(input int w);
        bit [N-2:0] p = m_plru;
        int lo = 0;
        int n = N;
        int node = 0;
        while (n > 1) begin
            n = n / 2;
            if (w < lo + n) begin p[node] = 1'b1; node = 2 * node + 1; end
            else begin p[node] = 1'b0; lo += n; node = 2 * node + 2; end
        end
        return p;
    endfunction

    function automatic logic [N-1:0] oh(input int w);
        return N'(1) << w;
    endfunction

    function automatic logic [2*N-1:0] wen_at(input int w, input logic [1:0] code);
        return (2 * N)'(code) << (2 * w);
    endfunction

    task automatic model_fill(input bit [N-2:0] pl);
        for (int i = 0; i < N; i++) begin
            m_tag[i] = 10 + i; m_valid[i] = 1'b1; m_dirty[i] = 1'b0;
        end
        m_plru = pl;
    endtask

    // One CPU request, checked every cycle until its response
    task automatic txn(input bit wr, input int tag, input int lwb, input int lal);
        int  h;
        int  v;
        bit  found;
        @(negedge clk);
        req_tag   = tag;
        mem_write = wr;
        mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        pmem_resp = 1'($urandom_range(0, 1));
        #1 exp_zero("idle_req");
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            pmem_resp = 1'($urandom_range(0, 1));
            #1;
            found = 1'b0; h = 0;
            for (int i = 0; i < N; i++)
                if (!found && m_valid[i] && m_tag[i] == tag) begin found = 1'b1; h = i; end
            if (found) begin
                exp_cycle(pass == 0 ? "hit" : "hit_after_fill", 1, 1, ref_touch(h), '0,
                          wr ? oh(h) : '0, '0, 0, wr, wr ? wen_at(h, 2'b10) : '0, '0, 0, 0, 0);
                @(posedge clk); #1;
                m_plru = ref_touch(h);
                if (wr) m_dirty[h] = 1'b1;
                mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
                return;
            end
            check("miss_phase", 64'(pass), 64'(0));
            exp_zero("miss");
            v = ref_victim();
            @(posedge clk); #1;
            check("victim", 64'(victim_way), 64'(v));
            if (m_valid[v] && m_dirty[v]) begin
                for (int c = 0; c < lwb; c++) begin
                    @(negedge clk);
                    pmem_resp = (c == lwb - 1);
                    #1 exp_cycle("write_back", 0, 0, '0, '0, '0, '0, 0, 0, '0, '0, 1, 0, 1);
                end
                @(posedge clk); #1 pmem_resp = 1'b0;
            end
            for (int c = 0; c < lal; c++) begin
                @(negedge clk);
                pmem_resp = (c == lal - 1);
                #1;
                if (c == lal - 1)
                    exp_cycle("alloc_fill", 0, 0, '0, oh(v), oh(v), oh(v), 1, 0,
                              wen_at(v, 2'b01), oh(v), 0, 1, 0);
                else
                    exp_cycle("alloc_wait", 0, 0, '0, '0, '0, '0, 0, 0, '0, '0, 0, 1, 0);
            end
            @(posedge clk); #1;
            pmem_resp  = 1'b0;
            m_tag[v]   = tag;
            m_valid[v] = 1'b1;
            m_dirty[v] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_fill('0);
        // Reset held low: everything quiet
        #12;
        exp_zero("reset_hold");
        check("reset_victim", 64'(victim_way), 64'(0));
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1 exp_zero("idle_no_req");
        end

        // Directed: read hit way 2, write hit way 1
        model_fill('0);
        txn(1'b0, 12, 1, 1);
        model_fill('0);
        txn(1'b1, 11, 1, 1);
        // Clean miss, all valid, victim 0, 5-cycle refill
        model_fill('0);
        txn(1'b0, 99, 1, 5);
        // Invalid-first: way 3 invalid, way 0 dirty
        model_fill('0);
        m_valid[3] = 1'b0; m_dirty[0] = 1'b1;
        txn(1'b1, 98, 1, 2);
        // Dirty PLRU victim on a write
        model_fill(3'b101);
        for (int i = 0; i < N; i++) m_dirty[i] = 1'b1;
        txn(1'b1, 97, 3, 2);

        // Reset asserted mid-ALLOCATE
        model_fill(3'b001);
        @(negedge clk); req_tag = 50; mem_read = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        check("pre_rst_pmem_read", 64'(pmem_read), 64'(1));
        check("pre_rst_victim", 64'(victim_way), 64'(2));
        #2 rst = 1'b0;
        #1 exp_zero("mid_op_reset");
        check("mid_op_reset_victim", 64'(victim_way), 64'(0));
        mem_read = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1 exp_zero("after_reset_idle");

        // Randomized traffic against the set model
        model_fill('0);
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                int k;
                k = int'($urandom_range(0, N - 1));
                m_valid[k] = 1'b0; m_dirty[k] = 1'b0;
            end
            txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end

        // N=2: dirty victim way 0 -> write-back, refill, re-check hit
        valid2 = 2'b11; dirty2 = 2'b01; plru2 = 1'b0; hit2 = 2'b00;
        @(negedge clk); mem_read2 = 1'b1;
        #1 check("n2_idle", 64'({mem_resp2, pmem_read2, pmem_write2, ld_plru2}), 64'(0));
        @(negedge clk); #1 check("n2_check_miss", 64'({mem_resp2, ld_plru2, pmem_read2, pmem_write2}), 64'(0));
        @(negedge clk); #1 check("n2_wb", 64'({pmem_write2, asel2, pmem_read2}), 64'(3'b110));
        check("n2_victim", 64'(victim2), 64'(0));
        @(negedge clk); pmem_resp2 = 1'b1;
        #1 check("n2_wb_last", 64'({pmem_write2, asel2, pmem_read2, ld_valid2}), 64'(5'b11000));
        @(posedge clk); #1 pmem_resp2 = 1'b0;
        @(negedge clk); #1 check("n2_alloc", 64'({pmem_read2, asel2, ld_valid2}), 64'(4'b1000));
        pmem_resp2 = 1'b1;
        #1 check("n2_alloc_fill",
                 64'({pmem_read2, ld_valid2, ld_tag2, ld_dirty2, valid_out2, dirty_out2, w_en2, dsel2}),
                 64'({1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 4'b0001, 2'b01}));
        @(posedge clk); #1 pmem_resp2 = 1'b0; hit2 = 2'b01; dirty2 = 2'b00;
        @(negedge clk); #1 check("n2_hit", 64'({mem_resp2, ld_plru2, plru_out2, pmem_read2}), 64'(4'b1110));
        @(posedge clk); #1 mem_read2 = 1'b0;
        @(negedge clk); #1 check("n2_done_idle", 64'({mem_resp2, pmem_read2, pmem_write2}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
